// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the shared sram port around mem_port_arbiter.
// The slave modport is the arbiter's view; master is the surrounding requesters plus sram.
interface mem_port_arbiter_if #(
  parameter int AW = 25
);
  logic          copy_req;
  logic          copy_we;
  logic [AW-1:0] copy_addr;
  logic [15:0]   copy_din;
  logic          copy_ack;

  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_din;
  logic [1:0]    cpu_wtbt;
  logic          cpu_ack;

  logic          dsk_req;
  logic          dsk_we;
  logic [AW-1:0] dsk_addr;
  logic [15:0]   dsk_din;
  logic          dsk_ack;

  logic [15:0]   rd_data;

  logic [AW-1:0] ram_addr;
  logic [15:0]   ram_din;
  logic [1:0]    ram_wtbt;
  logic          ram_we;
  logic          ram_rd;
  logic          ram_ready;
  logic [15:0]   ram_dout;

  logic          busy;
  logic          timeout_err;

  modport slave (
    input  copy_req, copy_we, copy_addr, copy_din,
    output copy_ack,
    input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wtbt,
    output cpu_ack,
    input  dsk_req, dsk_we, dsk_addr, dsk_din,
    output dsk_ack,
    output rd_data,
    output ram_addr, ram_din, ram_wtbt, ram_we, ram_rd,
    input  ram_ready, ram_dout,
    output busy, timeout_err
  );

  modport master (
    output copy_req, copy_we, copy_addr, copy_din,
    input  copy_ack,
    output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_wtbt,
    input  cpu_ack,
    output dsk_req, dsk_we, dsk_addr, dsk_din,
    input  dsk_ack,
    input  rd_data,
    input  ram_addr, ram_din, ram_wtbt, ram_we, ram_rd,
    output ram_ready, ram_dout,
    input  busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Three-way arbiter for the single sram port: copy loader, mapped CPU bus and disk DMA.
// One transaction at a time, latched at grant, single-cycle ack, DMA anti-starvation.
module mem_port_arbiter #(
  parameter int AW          = 25,
  parameter int TIMEOUT     = 255,
  parameter int DSK_MAXWAIT = 8
) (
  input  logic              clk_sys,
  input  logic              init_n,
  mem_port_arbiter_if.slave bus
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [1:0] GR_COPY = 2'd0;
  localparam logic [1:0] GR_CPU  = 2'd1;
  localparam logic [1:0] GR_DSK  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    grant;
  logic          lat_we;
  logic [TW-1:0] to_cnt;
  logic [3:0]    starve_cnt;

  logic [AW-1:0] ram_addr_q;
  logic [15:0]   ram_din_q;
  logic [1:0]    ram_wtbt_q;
  logic          ram_we_q;
  logic          ram_rd_q;
  logic [15:0]   rd_data_q;
  logic          copy_ack_q;
  logic          cpu_ack_q;
  logic          dsk_ack_q;
  logic          timeout_err_q;

  logic          dsk_forced;
  logic          win_valid;
  logic [1:0]    win_sel;
  logic          win_we;
  logic [AW-1:0] win_addr;
  logic [15:0]   win_din;
  logic [1:0]    win_wtbt;
  logic          win_empty;
  logic          ram_done;
  logic          ram_expired;

  assign dsk_forced = ({28'd0, starve_cnt} >= 32'(DSK_MAXWAIT));

  // Fixed priority with the starved DMA slotted in between copy and CPU.
  always_comb begin
    win_valid = 1'b0;
    win_sel   = GR_CPU;
    win_we    = 1'b0;
    win_addr  = '0;
    win_din   = '0;
    win_wtbt  = 2'b11;
    if (bus.copy_req) begin
      win_valid = 1'b1;
      win_sel   = GR_COPY;
      win_we    = bus.copy_we;
      win_addr  = bus.copy_addr;
      win_din   = bus.copy_din;
    end else if (bus.dsk_req && dsk_forced) begin
      win_valid = 1'b1;
      win_sel   = GR_DSK;
      win_we    = bus.dsk_we;
      win_addr  = bus.dsk_addr;
      win_din   = bus.dsk_din;
    end else if (bus.cpu_req) begin
      win_valid = 1'b1;
      win_sel   = GR_CPU;
      win_we    = bus.cpu_we;
      win_addr  = bus.cpu_addr;
      win_din   = bus.cpu_din;
      win_wtbt  = bus.cpu_wtbt;
    end else if (bus.dsk_req) begin
      win_valid = 1'b1;
      win_sel   = GR_DSK;
      win_we    = bus.dsk_we;
      win_addr  = bus.dsk_addr;
      win_din   = bus.dsk_din;
    end
  end

  assign win_empty   = win_valid && (win_sel == GR_CPU) && win_we && (win_wtbt == 2'b00);
  assign ram_done    = (state == ST_WAIT) && bus.ram_ready;
  assign ram_expired = (state == ST_WAIT) && !bus.ram_ready && (to_cnt == TO_LAST);

  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) begin
      state         <= ST_IDLE;
      grant         <= GR_COPY;
      lat_we        <= 1'b0;
      ram_addr_q    <= '0;
      ram_din_q     <= '0;
      ram_wtbt_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      copy_ack_q    <= 1'b0;
      cpu_ack_q     <= 1'b0;
      dsk_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      ram_we_q      <= 1'b0;
      ram_rd_q      <= 1'b0;
      copy_ack_q    <= 1'b0;
      cpu_ack_q     <= 1'b0;
      dsk_ack_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            grant      <= win_sel;
            lat_we     <= win_we;
            ram_addr_q <= win_addr & ~AW'(1);
            ram_din_q  <= win_din;
            ram_wtbt_q <= win_wtbt;
            if (win_empty) begin
              cpu_ack_q <= 1'b1;
              state     <= ST_DONE;
            end else begin
              ram_we_q  <= win_we;
              ram_rd_q  <= ~win_we;
              state     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_WAIT;
        ST_WAIT: begin
          if (ram_done || ram_expired) begin
            copy_ack_q    <= (grant == GR_COPY);
            cpu_ack_q     <= (grant == GR_CPU);
            dsk_ack_q     <= (grant == GR_DSK);
            timeout_err_q <= ram_expired;
            state         <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The wait budget restarts with every strobe, so each transaction gets the full window.
  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) begin
      to_cnt <= '0;
    end else if (state == ST_ISSUE) begin
      to_cnt <= '0;
    end else if ((state == ST_WAIT) && !ram_done && !ram_expired) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) begin
      rd_data_q <= '0;
    end else if (ram_done && !lat_we) begin
      rd_data_q <= bus.ram_dout;
    end else if (ram_expired && !lat_we) begin
      rd_data_q <= 16'hFFFF;
    end
  end

  // Counts CPU wins that overtook a waiting DMA request; copy wins leave it alone.
  always_ff @(posedge clk_sys or negedge init_n) begin
    if (!init_n) begin
      starve_cnt <= '0;
    end else if (state == ST_IDLE) begin
      if (!bus.dsk_req) begin
        starve_cnt <= '0;
      end else if (win_valid && (win_sel == GR_DSK)) begin
        starve_cnt <= '0;
      end else if (win_valid && (win_sel == GR_CPU) && (starve_cnt != 4'hF)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  assign bus.copy_ack    = copy_ack_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.dsk_ack     = dsk_ack_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_din     = ram_din_q;
  assign bus.ram_wtbt    = ram_wtbt_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_rd      = ram_rd_q;
  assign bus.busy        = (state != ST_IDLE);
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a reference model predicts grant order and read data,
// an sram model answers strobes, and a monitor pops expectations on every ack.
module tb_mem_port_arbiter;

  localparam int AW = 25;
  localparam int WHO_COPY = 0;
  localparam int WHO_CPU  = 1;
  localparam int WHO_DSK  = 2;

  typedef struct {
    bit          we;
    bit [AW-1:0] addr;
    bit [15:0]   din;
    bit [1:0]    wtbt;
  } txn_t;

  typedef struct {
    int          who;
    bit          we;
    bit [AW-1:0] addr;
    bit [15:0]   din;
    bit [1:0]    wtbt;
    bit [15:0]   exp_rd;
    bit          tmo;
    bit          empty;
  } exp_t;

  logic clk_sys = 1'b0;
  logic init_n  = 1'b0;

  mem_port_arbiter_if #(.AW(AW)) bus ();

  mem_port_arbiter #(
    .AW          (AW),
    .TIMEOUT     (255),
    .DSK_MAXWAIT (8)
  ) dut (
    .clk_sys (clk_sys),
    .init_n  (init_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  exp_t exp_q[$];
  txn_t q_copy[$];
  txn_t q_cpu[$];
  txn_t q_dsk[$];

  logic [15:0] sram_mem [int];
  logic [15:0] ref_mem  [int];
  bit          no_response = 1'b0;
  int          ram_lat     = 0;
  logic [15:0] last_rd     = 16'h0000;

  int          strobes_since = 0;
  int          strobe_cyc    = 0;
  int          ready_cyc     = 0;
  int          pend_cnt      = 0;
  logic [15:0] pend_data     = 16'h0000;
  logic [AW-1:0] last_addr   = '0;
  logic        last_we       = 1'b0;
  logic [1:0]  last_wtbt     = 2'b00;
  logic [15:0] last_din      = 16'h0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int widx(input logic [AW-1:0] a);
    return int'(a >> 1);
  endfunction

  function automatic logic [15:0] dflt(input int w);
    return 16'((w * 40503) ^ 23100);
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                        input logic [1:0] be);
    logic [15:0] r;
    r = old;
    if (be[1]) r[15:8] = nw[15:8];
    if (be[0]) r[7:0]  = nw[7:0];
    return r;
  endfunction

  // sram model plus ack monitor, both sampling on the falling edge
  initial begin
    bus.ram_ready = 1'b0;
    bus.ram_dout  = 16'h0000;
    forever begin
      @(negedge clk_sys);
      bus.ram_ready = 1'b0;
      if (!init_n) begin
        pend_cnt      = 0;
        strobes_since = 0;
        continue;
      end
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.ram_ready = 1'b1;
          bus.ram_dout  = pend_data;
          ready_cyc     = cyc;
        end
      end
      if (bus.ram_we || bus.ram_rd) begin
        int w;
        logic [15:0] cur;
        checkOutput("strobe_exclusive", 32'(bus.ram_we & bus.ram_rd), 32'd0);
        strobes_since++;
        strobe_cyc = cyc;
        last_addr  = bus.ram_addr;
        last_we    = bus.ram_we;
        last_wtbt  = bus.ram_wtbt;
        last_din   = bus.ram_din;
        w   = widx(bus.ram_addr);
        cur = sram_mem.exists(w) ? sram_mem[w] : dflt(w);
        if (bus.ram_we) begin
          sram_mem[w] = merge(cur, bus.ram_din, bus.ram_wtbt);
          pend_data   = 16'($urandom);
        end else begin
          pend_data = cur;
        end
        if (!no_response) pend_cnt = (ram_lat > 0) ? ram_lat : int'($urandom_range(1, 5));
      end
      if (bus.timeout_err) begin
        checkOutput("tmo_with_ack", 32'(bus.copy_ack | bus.cpu_ack | bus.dsk_ack), 32'd1);
      end
      if (bus.copy_ack || bus.cpu_ack || bus.dsk_ack) begin
        int who;
        exp_t e;
        who = bus.copy_ack ? WHO_COPY : (bus.cpu_ack ? WHO_CPU : WHO_DSK);
        checkOutput("ack_onehot", 32'(bus.copy_ack) + 32'(bus.cpu_ack) + 32'(bus.dsk_ack), 32'd1);
        checkOutput("ack_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          checkOutput("grant_order", 32'(who), 32'(e.who));
          checkOutput("rd_data", 32'(bus.rd_data), 32'(e.exp_rd));
          checkOutput("timeout_err", 32'(bus.timeout_err), 32'(e.tmo));
          if (e.empty) begin
            checkOutput("empty_wr_no_strobe", 32'(strobes_since), 32'd0);
          end else begin
            checkOutput("one_strobe", 32'(strobes_since), 32'd1);
            checkOutput("ram_addr", 32'(last_addr), 32'(e.addr & ~AW'(1)));
            checkOutput("ram_we", 32'(last_we), 32'(e.we));
            if (e.we) begin
              checkOutput("ram_din", 32'(last_din), 32'(e.din));
              checkOutput("ram_wtbt", 32'(last_wtbt), 32'(e.wtbt));
            end
            if (e.tmo) checkOutput("tmo_latency", 32'(cyc - strobe_cyc), 32'd256);
            else       checkOutput("ack_after_ready", 32'(cyc - ready_cyc), 32'd1);
          end
        end
        strobes_since = 0;
      end
    end
  end

  task automatic genTxns(input int nc, input int nu, input int nd);
    txn_t t;
    for (int i = 0; i < nc + nu + nd; i++) begin
      t.we   = 1'($urandom_range(0, 1));
      t.addr = AW'($urandom_range(0, 47)) | AW'(25'h0_1000);
      t.din  = 16'($urandom);
      t.wtbt = 2'($urandom_range(0, 3));
      if (i < nc)           q_copy.push_back(t);
      else if (i < nc + nu) q_cpu.push_back(t);
      else                  q_dsk.push_back(t);
    end
  endtask

  task automatic driveCopy(input txn_t t);
    bus.copy_we = t.we; bus.copy_addr = t.addr; bus.copy_din = t.din;
  endtask

  task automatic driveCpu(input txn_t t);
    bus.cpu_we = t.we; bus.cpu_addr = t.addr; bus.cpu_din = t.din; bus.cpu_wtbt = t.wtbt;
  endtask

  task automatic driveDsk(input txn_t t);
    bus.dsk_we = t.we; bus.dsk_addr = t.addr; bus.dsk_din = t.din;
  endtask

  // Predicts the whole round from the arbitration rules, then lets all requesters loose at once.
  task automatic applyStimulus(output int first_ack_cyc, output int drive_cyc);
    int nc, nu, nd, ic, iu, id, cnt, n, acks, budget, w;
    bit dp;
    txn_t t;
    exp_t e;
    logic [15:0] cur;
    nc = q_copy.size(); nu = q_cpu.size(); nd = q_dsk.size();
    n = nc + nu + nd;
    ic = 0; iu = 0; id = 0; cnt = 0;
    while (ic < nc || iu < nu || id < nd) begin
      dp = (id < nd);
      if (!dp) cnt = 0;
      if (ic < nc)               begin e.who = WHO_COPY; t = q_copy[ic]; ic++; end
      else if (dp && cnt >= 8)   begin e.who = WHO_DSK;  t = q_dsk[id];  id++; end
      else if (iu < nu)          begin e.who = WHO_CPU;  t = q_cpu[iu];  iu++; end
      else                       begin e.who = WHO_DSK;  t = q_dsk[id];  id++; end
      if (e.who == WHO_CPU && dp && cnt < 15) cnt++;
      if (e.who == WHO_DSK) cnt = 0;
      e.we    = t.we;
      e.addr  = t.addr;
      e.din   = t.din;
      e.wtbt  = (e.who == WHO_CPU) ? t.wtbt : 2'b11;
      e.empty = (e.who == WHO_CPU) && t.we && (t.wtbt == 2'b00);
      e.tmo   = no_response && !e.empty;
      if (!e.empty) begin
        w   = widx(t.addr);
        cur = ref_mem.exists(w) ? ref_mem[w] : dflt(w);
        if (t.we) ref_mem[w] = merge(cur, t.din, e.wtbt);
        else      last_rd    = e.tmo ? 16'hFFFF : cur;
      end
      e.exp_rd = last_rd;
      exp_q.push_back(e);
    end

    @(negedge clk_sys);
    drive_cyc     = cyc;
    first_ack_cyc = -1;
    if (nc > 0) begin driveCopy(q_copy[0]); bus.copy_req = 1'b1; end
    if (nu > 0) begin driveCpu(q_cpu[0]);   bus.cpu_req  = 1'b1; end
    if (nd > 0) begin driveDsk(q_dsk[0]);   bus.dsk_req  = 1'b1; end
    acks   = 0;
    budget = n * 300 + 50;
    while (acks < n && budget > 0) begin
      @(negedge clk_sys);
      budget--;
      if (bus.copy_ack || bus.cpu_ack || bus.dsk_ack) begin
        acks++;
        if (first_ack_cyc < 0) first_ack_cyc = cyc;
      end
      if (bus.copy_ack && q_copy.size() > 0) begin
        void'(q_copy.pop_front());
        if (q_copy.size() > 0) driveCopy(q_copy[0]); else bus.copy_req = 1'b0;
      end
      if (bus.cpu_ack && q_cpu.size() > 0) begin
        void'(q_cpu.pop_front());
        if (q_cpu.size() > 0) driveCpu(q_cpu[0]); else bus.cpu_req = 1'b0;
      end
      if (bus.dsk_ack && q_dsk.size() > 0) begin
        void'(q_dsk.pop_front());
        if (q_dsk.size() > 0) driveDsk(q_dsk[0]); else bus.dsk_req = 1'b0;
      end
    end
    checkOutput("round_complete", 32'(acks), 32'(n));
    bus.copy_req = 1'b0; bus.cpu_req = 1'b0; bus.dsk_req = 1'b0;
    q_copy.delete(); q_cpu.delete(); q_dsk.delete();
    repeat (3) @(negedge clk_sys);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    txn_t t;
    int fa, dc;
    bus.copy_req = 1'b0; bus.copy_we = 1'b0; bus.copy_addr = '0; bus.copy_din = '0;
    bus.cpu_req  = 1'b0; bus.cpu_we  = 1'b0; bus.cpu_addr  = '0; bus.cpu_din  = '0;
    bus.cpu_wtbt = 2'b00;
    bus.dsk_req  = 1'b0; bus.dsk_we  = 1'b0; bus.dsk_addr  = '0; bus.dsk_din  = '0;
    repeat (3) @(negedge clk_sys);
    checkOutput("reset_ctrl", {26'd0, bus.busy, bus.copy_ack, bus.cpu_ack, bus.dsk_ack,
                               bus.ram_we, bus.ram_rd}, 32'd0);
    checkOutput("reset_rd_data", 32'(bus.rd_data), 32'd0);
    checkOutput("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    init_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    $display("[TB] single cpu read with 3-cycle sram latency");
    t.we = 1'b1; t.addr = 25'h100; t.din = 16'h1234; t.wtbt = 2'b11;
    q_copy.push_back(t);
    applyStimulus(fa, dc);
    t.we = 1'b0;
    q_cpu.push_back(t);
    ram_lat = 3;
    applyStimulus(fa, dc);
    ram_lat = 0;
    checkOutput("read_strobe_latency", 32'(strobe_cyc - dc), 32'd1);
    checkOutput("read_rd_data", 32'(bus.rd_data), 32'h1234);

    $display("[TB] simultaneous copy/cpu/dsk requests");
    genTxns(1, 1, 1);
    applyStimulus(fa, dc);

    $display("[TB] continuous cpu load against dma");
    genTxns(0, 20, 2);
    applyStimulus(fa, dc);

    $display("[TB] cpu writes with empty and partial byte enables");
    t.we = 1'b1; t.addr = 25'h200; t.din = 16'hBEEF; t.wtbt = 2'b00;
    q_cpu.push_back(t);
    applyStimulus(fa, dc);
    checkOutput("empty_wr_latency", 32'((fa - dc) >= 1 && (fa - dc) <= 2), 32'd1);
    t.wtbt = 2'b10; t.din = 16'hA55A;
    q_cpu.push_back(t);
    applyStimulus(fa, dc);

    $display("[TB] sram never answers");
    no_response = 1'b1;
    t.we = 1'b0; t.addr = 25'h300; t.wtbt = 2'b11;
    q_cpu.push_back(t);
    applyStimulus(fa, dc);
    no_response = 1'b0;
    checkOutput("tmo_rd_data", 32'(bus.rd_data), 32'hFFFF);
    checkOutput("tmo_back_idle", 32'(bus.busy), 32'd0);

    $display("[TB] reset during wait");
    no_response = 1'b1;
    @(negedge clk_sys);
    bus.cpu_we = 1'b0; bus.cpu_addr = 25'h40; bus.cpu_wtbt = 2'b11; bus.cpu_req = 1'b1;
    repeat (6) @(negedge clk_sys);
    checkOutput("busy_in_wait", 32'(bus.busy), 32'd1);
    init_n = 1'b0;
    #1;
    checkOutput("midreset_ctrl", {8'd0, bus.rd_data, bus.busy, bus.copy_ack, bus.cpu_ack,
                                  bus.dsk_ack, bus.ram_we, bus.ram_rd, bus.timeout_err,
                                  bus.ram_wtbt[1]}, 32'd0);
    checkOutput("midreset_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("midreset_din", {16'd0, bus.ram_din}, {16'd0, 14'd0, bus.ram_wtbt});
    bus.cpu_req = 1'b0;
    last_rd = 16'h0000;
    repeat (3) @(negedge clk_sys);
    init_n = 1'b1;
    no_response = 1'b0;
    repeat (2) @(negedge clk_sys);
    t.we = 1'b0; t.addr = 25'h40; t.wtbt = 2'b11;
    q_cpu.push_back(t);
    applyStimulus(fa, dc);

    $display("[TB] random rounds");
    for (int r = 0; r < 25; r++) begin
      int nc, nu, nd;
      nc = int'($urandom_range(0, 2));
      nu = int'($urandom_range(0, 11));
      nd = int'($urandom_range(0, 2));
      if (nc + nu + nd == 0) nu = 1;
      genTxns(nc, nu, nd);
      applyStimulus(fa, dc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
